// File: rtl/gpio_led_pwm_driver.sv
// LED output stage behind the GPIO register: per-channel 8-bit PWM dimming,
// a shared blink gate and a 4-word CPU register window.
module gpio_led_pwm_driver #(
    parameter int BLINK_DIV = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_sel,
    input  logic        i_we,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    input  logic [3:0]  i_gpio,
    output logic [3:0]  o_led
);

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);

    logic        en_q, en_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] duty_q, duty_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] presc_cnt_q, presc_cnt_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;
    logic        blink_phase_q, blink_phase_d;
    logic [3:0]  led_q, led_d;
    logic        tick, wrap;

    always_comb begin
        en_d          = en_q;
        mask_d        = mask_q;
        duty_d        = duty_q;
        prescale_d    = prescale_q;
        presc_cnt_d   = presc_cnt_q;
        pwm_cnt_d     = pwm_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        led_d         = led_q;

        if (i_sel && i_we) begin
            case (i_addr)
                2'd0: begin
                    en_d   = i_wdata[0];
                    mask_d = i_wdata[7:4];
                end
                2'd1:    duty_d     = i_wdata;
                2'd2:    prescale_d = i_wdata[15:0];
                default: ;
            endcase
        end

        // Compare against the live PRESCALE so a lowered value never strands the counter.
        tick = en_q && (presc_cnt_q >= prescale_q);
        wrap = tick && (pwm_cnt_q == 8'hFF);

        presc_cnt_d = tick ? 16'd0 : (en_q ? presc_cnt_q + 16'd1 : presc_cnt_q);
        if (tick)
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        if (wrap) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = 8'd0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end

        // A disable in the same cycle as a tick or wrap takes priority.
        if (!en_d) begin
            presc_cnt_d   = 16'd0;
            pwm_cnt_d     = 8'd0;
            blink_cnt_d   = 8'd0;
            blink_phase_d = 1'b1;
        end

        for (int n = 0; n < 4; n++) begin
            if (en_q)
                led_d[n] = i_gpio[n] & (pwm_cnt_q < duty_q[8*n +: 8])
                         & (~mask_q[n] | blink_phase_q);
            else
                led_d[n] = i_gpio[n];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q          <= 1'b0;
            mask_q        <= 4'd0;
            duty_q        <= 32'd0;
            prescale_q    <= 16'd0;
            presc_cnt_q   <= 16'd0;
            pwm_cnt_q     <= 8'd0;
            blink_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b1;
            led_q         <= 4'd0;
        end else begin
            en_q          <= en_d;
            mask_q        <= mask_d;
            duty_q        <= duty_d;
            prescale_q    <= prescale_d;
            presc_cnt_q   <= presc_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_q         <= led_d;
        end
    end

    always_comb begin
        case (i_addr)
            2'd0:    o_rdata = {24'd0, mask_q, 3'd0, en_q};
            2'd1:    o_rdata = duty_q;
            2'd2:    o_rdata = {16'd0, prescale_q};
            default: o_rdata = {15'd0, blink_phase_q, 4'd0, led_q, pwm_cnt_q};
        endcase
    end

    assign o_led = led_q;

endmodule
